instr_issuer: RTL and testbench
===============================

Name: instr_issuer

Overview:
- Host-side front end for the processor datapath's control unit.
- Accepts instruction fields from a host over a valid/ready handshake and packs them into the 16-bit instruction word.
- Buffers encoded words in a small FIFO and issues them one at a time.
- Drives run and instruction, and holds each word stable until the control unit's done1/done2 handshake completes.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, 2..16)
- TAIL_CYCLES, 1, run-high cycles after done2 before the next word is presented or run drops (1..3)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  issuer can accept a command
- cmd_fmt  in  2  format: 00 R, 01 I, 10 J, 11 illegal
- cmd_alu  in  3  ALU select
- cmd_rd  in  3  destination/first operand register
- cmd_rs  in  3  second operand register (ignored for I)
- cmd_imm  in  8  immediate (I only)
- run  out  1  advance enable to the control unit
- instruction  out  16  word presented to the control unit
- done1  in  1  control unit store-cycle pulse
- done2  in  1  control unit delay-cycle pulse
- busy  out  1  an instruction is in flight
- fifo_count  out  $clog2(DEPTH)+1  buffered words
- issued_count  out  16  completed instructions, wraps at 0xFFFF
- err_fmt  out  1  one-cycle pulse when an illegal-format command is dropped

Behaviour:
- Reset values (asynchronous, active-high): all FSM, FIFO and counter state and all outputs cleared.
  - run=0, instruction=0, busy=0, fifo_count=0, issued_count=0, err_fmt=0.
  - cmd_ready=1 in the first cycle after reset deasserts.
- Encoding, combinational from cmd_* fields:
  - [1:0]=fmt, [4:2]=alu, [15:13]=rd.
  - R/J: [12:10]=rs, [9:5]=0.
  - I: [12:5]=imm; rs is ignored.
- Accept rule:
  - A command is accepted on a clk edge with cmd_valid && cmd_ready.
  - cmd_ready = !fifo_full.
  - fmt=11: the command is accepted (handshake completes), not written, and err_fmt pulses the next cycle.
- FIFO:
  - Circular buffer, wrap-around pointers; push and pop in the same cycle are allowed.
  - When full, a simultaneous pop frees a slot only in the next cycle; cmd_ready is not combinationally dependent on the pop.
- Issue FSM states:
  - IDLE: run=0, busy=0. FIFO non-empty -> ISSUE; pop the head into the instruction output register in that same transition.
  - ISSUE: run=1, busy=1, instruction held constant. done1 -> DRAIN.
  - DRAIN: run=1. done2 -> TAIL; issued_count increments on this edge.
  - TAIL: run=1 for TAIL_CYCLES cycles, instruction still held.
    - At the end, FIFO non-empty -> ISSUE with the next word popped and loaded.
    - FIFO empty -> IDLE.
- Instruction output: updated only on IDLE->ISSUE and TAIL->ISSUE transitions; otherwise held, including in IDLE (last word retained).
- First instruction after reset: no special priming. The run-high cycles in ISSUE carry the control unit from its reset state to the store step; the issuer only waits for done1.
- done1 outside ISSUE, or done2 outside DRAIN: ignored (no state change).
- done1 and done2 asserted in the same cycle while in ISSUE: treated as done1 only.
- Reset mid-operation: the in-flight instruction and all buffered words are discarded; issued_count is not incremented.
- Latency: a command accepted into an empty FIFO while in IDLE appears on instruction with run=1 two cycles after the accept edge (one cycle to write, one to pop).

Decomposition:
- Shared package instr_pkg:
  - Format codes FMT_R=2'b00, FMT_I=2'b01, FMT_J=2'b10.
  - Field bit positions for fmt/alu/rd/rs/imm.
  - Issuer FSM state encoding.
- Sub-module instr_fifo: parameterised width/depth synchronous FIFO with push, pop, full, empty and count. Encoder and FSM live in instr_issuer.

Test Plan:
- Reset, then push R cmd (alu=3'b010, rd=1, rs=2) -> instruction=0x2808, run=1 two cycles after accept. Hold until done1 then done2; issued_count=1; after TAIL, run=0 in IDLE.
- Push I cmd (alu=3'b000, rd=3, imm=0xA5) with cmd_rs=7 -> instruction=0x74A1; rs does not corrupt the immediate.
- Push fmt=11 -> cmd_ready stays 1, err_fmt pulses once, fifo_count stays 0, run stays 0.
- Push DEPTH+1 commands back-to-back with done1/done2 withheld.
  - cmd_ready=0 once full, with fifo_count=4 after the first word was popped into ISSUE.
  - Release handshakes -> words issue in order, each held until its done2.
- Assert done2 while in ISSUE, and done1 while in DRAIN -> no state change; issued_count unchanged.
- Assert reset while in DRAIN with 2 words buffered -> all outputs at reset values next cycle; no stale word issues after reset release.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction issuer: format codes, field
// positions inside the 16-bit instruction word, issuer FSM states and the
// field encoder.
package instr_pkg;

    localparam int INSTR_W = 16;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_ILL = 2'b11;

    // Least significant bit of each field in the instruction word
    localparam int FMT_LSB = 0;   // [1:0]
    localparam int ALU_LSB = 2;   // [4:2]
    localparam int IMM_LSB = 5;   // [12:5], I format only
    localparam int RS_LSB  = 10;  // [12:10], R/J formats
    localparam int RD_LSB  = 13;  // [15:13]

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_TAIL  = 2'd3
    } issue_state_t;

    // Pack host fields into an instruction word. R/J words keep [9:5] zero;
    // I words carry the immediate in [12:5] and never look at rs.
    function automatic logic [INSTR_W-1:0] encode_instr(
        input logic [1:0] fmt,
        input logic [2:0] alu,
        input logic [2:0] rd,
        input logic [2:0] rs,
        input logic [7:0] imm
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[FMT_LSB +: 2] = fmt;
        w[ALU_LSB +: 3] = alu;
        w[RD_LSB  +: 3] = rd;
        if (fmt == FMT_I) begin
            w[IMM_LSB +: 8] = imm;
        end else if ((fmt == FMT_R) || (fmt == FMT_J)) begin
            w[RS_LSB +: 3] = rs;
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular-buffer synchronous FIFO with wrap-around pointers. Read data is
// the current head entry; push and pop may happen in the same cycle.
module instr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Host front end for the control unit: encodes host commands, buffers the
// words and presents them one at a time, holding each until done1/done2.
module instr_issuer
    import instr_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TAIL_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_fmt,
    input  logic [2:0]               cmd_alu,
    input  logic [2:0]               cmd_rd,
    input  logic [2:0]               cmd_rs,
    input  logic [7:0]               cmd_imm,
    output logic                     run,
    output logic [INSTR_W-1:0]       instruction,
    input  logic                     done1,
    input  logic                     done2,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issued_count,
    output logic                     err_fmt
);

    localparam logic [1:0] TAIL_LAST = 2'(TAIL_CYCLES - 1);

    issue_state_t       r_state;
    logic [1:0]         r_tail_cnt;
    logic               r_run;
    logic               r_busy;
    logic [INSTR_W-1:0] r_instr;
    logic [15:0]        r_issued;
    logic               r_err_fmt;

    logic [INSTR_W-1:0] w_enc;
    logic [INSTR_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_tail_end;
    logic               w_pop;

    // cmd_ready depends only on registered occupancy, never on this cycle's pop
    assign cmd_ready  = !w_full;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_push     = w_accept && (cmd_fmt != FMT_ILL);
    assign w_enc      = encode_instr(cmd_fmt, cmd_alu, cmd_rd, cmd_rs, cmd_imm);
    assign w_tail_end = (r_state == ST_TAIL) && (r_tail_cnt == TAIL_LAST);
    assign w_pop      = !w_empty && ((r_state == ST_IDLE) || w_tail_end);

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_enc),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // Issue FSM: loads the head word on issue and tracks the done1/done2 handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tail_cnt <= '0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_instr    <= '0;
            r_issued   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_ISSUE;
                        r_run   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_instr <= w_head;
                    end
                end
                ST_ISSUE: begin
                    // done1 wins if done2 arrives in the same cycle
                    if (done1) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (done2) begin
                        r_state    <= ST_TAIL;
                        r_tail_cnt <= '0;
                        r_issued   <= r_issued + 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (w_tail_end) begin
                        if (w_pop) begin
                            r_state <= ST_ISSUE;
                            r_instr <= w_head;
                        end else begin
                            r_state <= ST_IDLE;
                            r_run   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_tail_cnt <= r_tail_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // One-cycle pulse after an illegal-format command is swallowed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_fmt <= 1'b0;
        end else begin
            r_err_fmt <= w_accept && (cmd_fmt == FMT_ILL);
        end
    end

    assign run          = r_run;
    assign busy         = r_busy;
    assign instruction  = r_instr;
    assign issued_count = r_issued;
    assign err_fmt      = r_err_fmt;

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_instr_issuer;

    localparam int DEPTH = 4;
    localparam int TAIL  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_fmt;
    logic [2:0]  cmd_alu;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs;
    logic [7:0]  cmd_imm;
    logic        run;
    logic [15:0] instruction;
    logic        done1;
    logic        done2;
    logic        busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0] issued_count;
    logic        err_fmt;

    int total = 0;
    int bad   = 0;

    instr_issuer #(.DEPTH(DEPTH), .TAIL_CYCLES(TAIL)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_fmt      (cmd_fmt),
        .cmd_alu      (cmd_alu),
        .cmd_rd       (cmd_rd),
        .cmd_rs       (cmd_rs),
        .cmd_imm      (cmd_imm),
        .run          (run),
        .instruction  (instruction),
        .done1        (done1),
        .done2        (done2),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .issued_count (issued_count),
        .err_fmt      (err_fmt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_q[$];
    logic [15:0] m_instr;
    logic [15:0] m_issued;
    bit          m_inflight;
    bit          m_got_d1;
    int          m_tail_left;
    bit          m_err;

    function automatic int enc(int fmt, int alu, int rd, int rs, int imm);
        return fmt + alu * 4 + rd * 8192 + ((fmt == 1) ? imm * 32 : rs * 1024);
    endfunction

    task automatic model_step();
        int n;
        bit acc;
        if (reset) begin
            m_q.delete();
            m_instr = '0; m_issued = '0; m_inflight = 0;
            m_got_d1 = 0; m_tail_left = 0; m_err = 0;
        end else begin
            n   = m_q.size();
            acc = cmd_valid && (n < DEPTH);
            m_err = acc && (cmd_fmt == 2'b11);
            if (!m_inflight) begin
                if (n > 0) begin
                    m_instr = 16'(m_q.pop_front());
                    m_inflight = 1; m_got_d1 = 0; m_tail_left = 0;
                end
            end else if (m_tail_left > 0) begin
                if (m_tail_left == 1) begin
                    m_got_d1 = 0; m_tail_left = 0;
                    if (n > 0) m_instr = 16'(m_q.pop_front());
                    else m_inflight = 0;
                end else begin
                    m_tail_left--;
                end
            end else if (!m_got_d1) begin
                if (done1) m_got_d1 = 1;
            end else if (done2) begin
                m_tail_left = TAIL;
                m_issued = m_issued + 16'd1;
            end
            if (acc && cmd_fmt != 2'b11)
                m_q.push_back(enc(cmd_fmt, cmd_alu, cmd_rd, cmd_rs, cmd_imm));
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    // Cycle-by-cycle comparison on the falling edge
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("run",    run,          m_inflight);
            check("busy",   busy,         m_inflight);
            check("instr",  instruction,  m_instr);
            check("count",  fifo_count,   m_q.size());
            check("ready",  cmd_ready,    m_q.size() < DEPTH);
            check("issued", issued_count, m_issued);
            check("errfmt", err_fmt,      m_err);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout bound expired");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cmd(input int f, input int a, input int d, input int s, input int i);
        cmd_valid = 1'b1;
        cmd_fmt = 2'(f); cmd_alu = 3'(a); cmd_rd = 3'(d); cmd_rs = 3'(s); cmd_imm = 8'(i);
    endtask

    task automatic finish_one();
        done1 = 1'b1; @(negedge clk); done1 = 1'b0;
        done2 = 1'b1; @(negedge clk); done2 = 1'b0;
        repeat (TAIL) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 0; cmd_fmt = 0; cmd_alu = 0; cmd_rd = 0;
        cmd_rs = 0; cmd_imm = 0; done1 = 0; done2 = 0;
        repeat (3) @(negedge clk);
        check("rst_run", run, 0);
        check("rst_instr", instruction, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_issued", issued_count, 0);
        check("rst_err", err_fmt, 0);
        reset = 1'b0;
        #1 check("rst_ready", cmd_ready, 1);

        // R command: visible two edges after the accept edge
        @(negedge clk); set_cmd(0, 2, 1, 2, 0);
        @(negedge clk); cmd_valid = 0;
        check("r_run_early", run, 0);
        check("r_count_one", fifo_count, 1);
        @(negedge clk);
        check("r_run", run, 1);
        check("r_instr", instruction, 16'h2808);
        repeat (2) @(negedge clk);
        check("r_hold", instruction, 16'h2808);
        finish_one();
        check("r_issued", issued_count, 1);
        check("r_idle_run", run, 0);
        check("r_retained", instruction, 16'h2808);

        // I command with junk in rs
        set_cmd(1, 0, 3, 7, 8'hA5);
        @(negedge clk); cmd_valid = 0;
        @(negedge clk);
        check("i_instr", instruction, 16'h74A1);
        finish_one();
        check("i_issued", issued_count, 2);

        // Illegal format
        set_cmd(3, 5, 5, 5, 8'h55);
        #1 check("ill_ready", cmd_ready, 1);
        @(negedge clk); cmd_valid = 0;
        check("ill_err", err_fmt, 1);
        check("ill_count", fifo_count, 0);
        @(negedge clk);
        check("ill_err_off", err_fmt, 0);
        check("ill_run", run, 0);

        // Fill with handshakes withheld
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_cmd(0, i, i + 1, i, 0);
            @(negedge clk);
        end
        check("full_count", fifo_count, DEPTH);
        check("full_ready", cmd_ready, 0);
        check("full_first", instruction, 16'h2000);
        set_cmd(2, 7, 7, 7, 0);
        repeat (2) @(negedge clk);
        check("full_stall", fifo_count, DEPTH);
        cmd_valid = 0;
        done1 = 1; done2 = 1;
        begin
            int k;
            k = 0;
            while ((m_inflight || m_q.size() != 0) && k < 200) begin
                @(negedge clk); k++;
            end
            check("drain_bound", k < 200, 1);
        end
        done1 = 0; done2 = 0;
        check("drain_issued", issued_count, 7);

        // Out-of-state done pulses
        set_cmd(2, 1, 2, 3, 0);
        @(negedge clk); cmd_valid = 0;
        @(negedge clk);
        done2 = 1; @(negedge clk); done2 = 0;
        check("ooo_issued_a", issued_count, 7);
        check("ooo_run_a", run, 1);
        done1 = 1; @(negedge clk);
        @(negedge clk); done1 = 0;
        check("ooo_issued_b", issued_count, 7);
        done2 = 1; @(negedge clk); done2 = 0;
        check("ooo_issued_c", issued_count, 8);
        repeat (TAIL + 1) @(negedge clk);

        // Reset while in DRAIN with two words buffered
        for (int i = 0; i < 3; i++) begin
            set_cmd(0, 1, i + 2, 1, 0);
            @(negedge clk);
        end
        cmd_valid = 0;
        done1 = 1; @(negedge clk); done1 = 0;
        check("pre_rst_count", fifo_count, 2);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_run", run, 0);
        check("mid_rst_instr", instruction, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_issued", issued_count, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk); #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_run", run, 0);
        check("post_rst_count", fifo_count, 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int dens;
            dens = (c / 500) % 4;
            cmd_valid = ($urandom_range(3) < dens);
            cmd_fmt = 2'($urandom_range(3));
            cmd_alu = 3'($urandom); cmd_rd = 3'($urandom);
            cmd_rs = 3'($urandom);  cmd_imm = 8'($urandom);
            done1 = ($urandom_range(3) == 0);
            done2 = ($urandom_range(3) == 0);
            @(negedge clk);
        end
        cmd_valid = 0; done1 = 0; done2 = 0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
